// File: rtl/wb_mailbox_pkg.sv
// Shared register map, STATUS/CTRL bit positions and STATUS packing for wb_mailbox.
package wb_mailbox_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_IDX_W  = 2;
    localparam int unsigned STAT_CNT_W = 8;

    localparam logic [REG_IDX_W-1:0] REG_DATA   = 2'd0;
    localparam logic [REG_IDX_W-1:0] REG_STATUS = 2'd1;
    localparam logic [REG_IDX_W-1:0] REG_CTRL   = 2'd2;

    localparam int unsigned STAT_TX_EMPTY   = 0;
    localparam int unsigned STAT_TX_FULL    = 1;
    localparam int unsigned STAT_RX_EMPTY   = 2;
    localparam int unsigned STAT_RX_FULL    = 3;
    localparam int unsigned STAT_TX_OVF     = 4;
    localparam int unsigned STAT_RX_UDF     = 5;
    localparam int unsigned STAT_TX_CNT_LSB = 8;
    localparam int unsigned STAT_RX_CNT_LSB = 16;

    localparam int unsigned CTRL_TX_FLUSH = 0;
    localparam int unsigned CTRL_RX_FLUSH = 1;
    localparam int unsigned CTRL_CLR_ERR  = 2;

    // Assemble the STATUS word; unlisted bits read as zero.
    function automatic logic [DATA_W-1:0] pack_status(
        input logic                  tx_empty,
        input logic                  tx_full,
        input logic                  rx_empty,
        input logic                  rx_full,
        input logic                  tx_ovf,
        input logic                  rx_udf,
        input logic [STAT_CNT_W-1:0] tx_cnt,
        input logic [STAT_CNT_W-1:0] rx_cnt
    );
        logic [DATA_W-1:0] s;
        s                                    = '0;
        s[STAT_TX_EMPTY]                     = tx_empty;
        s[STAT_TX_FULL]                      = tx_full;
        s[STAT_RX_EMPTY]                     = rx_empty;
        s[STAT_RX_FULL]                      = rx_full;
        s[STAT_TX_OVF]                       = tx_ovf;
        s[STAT_RX_UDF]                       = rx_udf;
        s[STAT_TX_CNT_LSB +: STAT_CNT_W]     = tx_cnt;
        s[STAT_RX_CNT_LSB +: STAT_CNT_W]     = rx_cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; pointers carry one extra wrap bit.
module sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head_c,
    output logic [DEPTH_LOG2:0]   count_c,
    output logic                  full_c,
    output logic                  empty_c
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok_c;
    logic             push_ok_c;

    assign count_c = wr_ptr_q - rd_ptr_q;
    assign empty_c = (count_c == '0);
    assign full_c  = (count_c == PTR_W'(DEPTH));
    assign head_c  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // A pop frees the slot this edge, so a push into a full FIFO may land alongside it.
    assign pop_ok_c  = pop & ~empty_c;
    assign push_ok_c = push & (~full_c | pop_ok_c);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c && !flush) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone classic slave exposing a host-to-local TX FIFO, a local-to-host RX FIFO,
// and STATUS/CTRL registers.
module wb_mailbox
    import wb_mailbox_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_W-1:0]     dat_i,
    output logic [DATA_W-1:0]     dat_o,
    input  logic                  we_i,
    input  logic [3:0]            sel_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);

    logic                  ack_q, ack_d;
    logic [DATA_W-1:0]     dat_q, dat_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  rx_udf_q, rx_udf_d;

    logic [REG_IDX_W-1:0]  reg_idx_c;
    logic                  taken_c;
    logic                  wr_en_c;
    logic                  rd_en_c;
    logic                  ctrl_wr_c;
    logic                  tx_push_c, tx_pop_c, tx_flush_c;
    logic                  rx_push_c, rx_rd_c, rx_pop_c, rx_flush_c;
    logic                  clr_err_c;
    logic [DATA_W-1:0]     tx_head_c, rx_head_c;
    logic [DEPTH_LOG2:0]   tx_count_c, rx_count_c;
    logic                  tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
    logic [DATA_W-1:0]     status_c;
    logic                  unused_adr_c;

    // Only the word index is decoded; the remaining address bits are don't-care.
    assign unused_adr_c = ^adr_i;
    assign reg_idx_c    = adr_i[3:2];

    assign taken_c   = cyc_i & stb_i & ~ack_q;
    assign wr_en_c   = taken_c & we_i & (|sel_i);
    assign rd_en_c   = taken_c & ~we_i;
    assign ctrl_wr_c = wr_en_c & (reg_idx_c == REG_CTRL);

    assign tx_push_c  = wr_en_c & (reg_idx_c == REG_DATA);
    assign tx_pop_c   = ~tx_empty_c & tx_ready;
    assign tx_flush_c = ctrl_wr_c & dat_i[CTRL_TX_FLUSH];

    assign rx_push_c  = rx_valid & ~rx_full_c;
    assign rx_rd_c    = rd_en_c & (reg_idx_c == REG_DATA);
    assign rx_pop_c   = rx_rd_c & ~rx_empty_c;
    assign rx_flush_c = ctrl_wr_c & dat_i[CTRL_RX_FLUSH];
    assign clr_err_c  = ctrl_wr_c & dat_i[CTRL_CLR_ERR];

    assign status_c = pack_status(tx_empty_c, tx_full_c, rx_empty_c, rx_full_c,
                                  tx_ovf_q, rx_udf_q,
                                  STAT_CNT_W'(tx_count_c), STAT_CNT_W'(rx_count_c));

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_W)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (tx_push_c),
        .push_data (dat_i),
        .pop       (tx_pop_c),
        .flush     (tx_flush_c),
        .head_c    (tx_head_c),
        .count_c   (tx_count_c),
        .full_c    (tx_full_c),
        .empty_c   (tx_empty_c)
    );

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_W)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (rx_push_c),
        .push_data (rx_data),
        .pop       (rx_pop_c),
        .flush     (rx_flush_c),
        .head_c    (rx_head_c),
        .count_c   (rx_count_c),
        .full_c    (rx_full_c),
        .empty_c   (rx_empty_c)
    );

    // Read data, ack and sticky error flags; a new error outranks a same-edge clear.
    always_comb begin
        ack_d    = taken_c;
        dat_d    = '0;
        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;

        if (rd_en_c) begin
            unique case (reg_idx_c)
                REG_DATA:   dat_d = rx_empty_c ? '0 : rx_head_c;
                REG_STATUS: dat_d = status_c;
                default:    dat_d = '0;
            endcase
        end

        if (clr_err_c) begin
            tx_ovf_d = 1'b0;
            rx_udf_d = 1'b0;
        end
        if (tx_push_c && tx_full_c && !tx_pop_c) tx_ovf_d = 1'b1;
        if (rx_rd_c && rx_empty_c)               rx_udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    assign ack_o    = ack_q;
    assign dat_o    = dat_q;
    assign tx_valid = ~tx_empty_c;
    assign tx_data  = tx_head_c;
    assign rx_ready = ~rx_full_c;

endmodule
